// File: rtl/deser_ctrl_if.sv
// Handshake bundle for deser_ctrl: sample input stream, frame output stream, flush and fill status.
// The master modport is the collector itself; slave is the producer/consumer side.
interface deser_ctrl_if #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
);
  localparam int CW = $clog2(N_SAMPLES + 1);

  logic                           recv_val;
  logic                           recv_rdy;
  logic [BIT_WIDTH-1:0]           recv_msg;
  logic                           flush;
  logic                           send_val;
  logic                           send_rdy;
  logic [N_SAMPLES*BIT_WIDTH-1:0] send_msg;
  logic [CW-1:0]                  send_count;
  logic [CW-1:0]                  fill_level;

  modport master (
    input  recv_val, recv_msg, flush, send_rdy,
    output recv_rdy, send_val, send_msg, send_count, fill_level
  );

  modport slave (
    output recv_val, recv_msg, flush, send_rdy,
    input  recv_rdy, send_val, send_msg, send_count, fill_level
  );
endinterface

// File: rtl/deser_ctrl.sv
// Serial-to-parallel collector: packs N_SAMPLES samples into one frame, holds it until accepted,
// and can flush a zero-padded partial frame carrying its valid-slot count.
module deser_ctrl #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  deser_ctrl_if.master io
);
  localparam int IW = $clog2(N_SAMPLES);
  localparam int CW = $clog2(N_SAMPLES + 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t                                 state, state_nxt;
  logic [IW-1:0]                          index;
  logic [CW-1:0]                          count;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]    slots;
  logic                                   recv_fire;
  logic                                   send_fire;
  logic                                   last_slot;

  assign recv_fire = io.recv_val && (state == FILL);
  assign send_fire = io.send_rdy && (state == FULL);
  assign last_slot = (index == IW'(N_SAMPLES - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= FILL;
    else       state <= state_nxt;
  end

  // NOTE: combinational blocks assign every output a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL: if ((recv_fire && (last_slot || io.flush)) || (io.flush && index != '0))
              state_nxt = FULL;
      FULL: if (send_fire) state_nxt = FILL;
    endcase
  end

  // Handshake outputs depend only on the state register.
  always_comb begin
    io.recv_rdy   = (state == FILL);
    io.send_val   = (state == FULL);
    io.fill_level = (state == FILL) ? CW'(index) : count;
  end

  // NOTE: the slot bank is reset (and cleared after each frame) because unwritten slots of a
  // flushed frame must read as zero; state uses non-blocking assignments throughout.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      index <= '0;
      count <= '0;
      slots <= '0;
    end else if (state == FILL) begin
      if (recv_fire) begin
        slots[index] <= io.recv_msg;
        index        <= index + IW'(1);
        if (last_slot || io.flush) count <= CW'(index) + CW'(1);
      end else if (io.flush && index != '0) begin
        count <= CW'(index);
      end
    end else if (send_fire) begin
      index <= '0;
      count <= '0;
      slots <= '0;
    end
  end

  assign io.send_msg   = slots;
  assign io.send_count = count;
endmodule

// File: tb/tb_deser_ctrl.sv
// Directed bench for deser_ctrl (N_SAMPLES=4, BIT_WIDTH=8): expected frames go into a scoreboard
// queue when stimulus is issued; a monitor pops and compares on every output handshake.
module tb_deser_ctrl;
  localparam int BW = 8;
  localparam int NS = 4;

  typedef struct {
    logic [NS*BW-1:0] msg;
    logic [2:0]       cnt;
  } frame_t;

  logic   CLK;
  logic   RESET;
  int     total = 0;
  int     bad = 0;
  frame_t sb[$];
  bit     stall_done = 0;

  deser_ctrl_if #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) bus ();

  deser_ctrl #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .io   (bus)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Returns one ns after the rising edge on which the sample was accepted.
  task automatic send_sample(input logic [BW-1:0] d);
    bit done = 0;
    bus.recv_val = 1;
    bus.recv_msg = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CLK);
      if (bus.recv_rdy) done = 1;
      @(posedge CLK); #1;
    end
    if (!done) check("recv_timeout", 64'(bus.recv_rdy), 64'd1);
    bus.recv_val = 0;
  endtask

  task automatic push_frame(input logic [NS*BW-1:0] m, input logic [2:0] c);
    frame_t f;
    f.msg = m;
    f.cnt = c;
    sb.push_back(f);
  endtask

  // Monitor: every output handshake must match the oldest expected frame.
  initial begin
    frame_t f;
    forever begin
      @(negedge CLK);
      if (!RESET && bus.send_val && bus.send_rdy) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got %0h count %0d with empty scoreboard",
                   bus.send_msg, bus.send_count);
        end else begin
          f = sb.pop_front();
          check("frame_msg", 64'(bus.send_msg), 64'(f.msg));
          check("frame_count", 64'(bus.send_count), 64'(f.cnt));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NS*BW-1:0] exp_msg;
    logic [BW-1:0]    d;

    RESET = 1;
    bus.recv_val = 0;
    bus.recv_msg = '0;
    bus.flush    = 0;
    bus.send_rdy = 0;
    #1;
    check("rst_recv_rdy", 64'(bus.recv_rdy), 64'd1);
    check("rst_send_val", 64'(bus.send_val), 64'd0);
    check("rst_fill", 64'(bus.fill_level), 64'd0);
    check("rst_count", 64'(bus.send_count), 64'd0);
    check("rst_msg", 64'(bus.send_msg), 64'd0);
    repeat (2) @(posedge CLK);
    #1 RESET = 0;

    // Back-to-back full frame, consumer always ready.
    bus.send_rdy = 1;
    push_frame(32'h44332211, 3'd4);
    send_sample(8'h11);
    send_sample(8'h22);
    send_sample(8'h33);
    send_sample(8'h44);
    check("t1_send_val", 64'(bus.send_val), 64'd1);
    check("t1_recv_rdy_full", 64'(bus.recv_rdy), 64'd0);
    check("t1_msg", 64'(bus.send_msg), 64'h44332211);
    check("t1_count", 64'(bus.send_count), 64'd4);
    check("t1_fill_full", 64'(bus.fill_level), 64'd4);
    idle(1);
    check("t1_recv_rdy_after", 64'(bus.recv_rdy), 64'd1);
    check("t1_send_val_after", 64'(bus.send_val), 64'd0);

    // Backpressure: frame held, junk sample ignored while full.
    bus.send_rdy = 0;
    push_frame(32'hA4A3A2A1, 3'd4);
    send_sample(8'hA1);
    send_sample(8'hA2);
    send_sample(8'hA3);
    send_sample(8'hA4);
    bus.recv_val = 1;
    bus.recv_msg = 8'hFF;
    repeat (5) begin
      @(negedge CLK);
      check("t2_recv_rdy", 64'(bus.recv_rdy), 64'd0);
      check("t2_hold_msg", 64'(bus.send_msg), 64'hA4A3A2A1);
    end
    @(posedge CLK); #1;
    bus.send_rdy = 1;
    bus.recv_val = 0;
    idle(1);
    check("t2_send_val_after", 64'(bus.send_val), 64'd0);
    check("t2_fill_after", 64'(bus.fill_level), 64'd0);
    bus.send_rdy = 0;

    // Flush of a partial frame.
    send_sample(8'h05);
    send_sample(8'h06);
    check("t3_fill_pre", 64'(bus.fill_level), 64'd2);
    push_frame(32'h00000605, 3'd2);
    bus.flush = 1;
    idle(1);
    bus.flush = 0;
    check("t3_send_val", 64'(bus.send_val), 64'd1);
    check("t3_count", 64'(bus.send_count), 64'd2);
    check("t3_fill_full", 64'(bus.fill_level), 64'd2);
    bus.send_rdy = 1;
    idle(1);
    check("t3_fill_after", 64'(bus.fill_level), 64'd0);
    bus.send_rdy = 0;

    // Flush together with a sample fire.
    send_sample(8'h01);
    send_sample(8'h02);
    push_frame(32'h00030201, 3'd3);
    bus.recv_val = 1;
    bus.recv_msg = 8'h03;
    bus.flush    = 1;
    idle(1);
    bus.recv_val = 0;
    bus.flush    = 0;
    check("t4_send_val", 64'(bus.send_val), 64'd1);
    check("t4_count", 64'(bus.send_count), 64'd3);
    check("t4_msg", 64'(bus.send_msg), 64'h00030201);
    bus.send_rdy = 1;
    idle(1);
    bus.send_rdy = 0;
    // Flush on an empty frame is ignored.
    bus.flush = 1;
    idle(1);
    bus.flush = 0;
    check("t4_empty_flush_val", 64'(bus.send_val), 64'd0);
    idle(1);
    check("t4_empty_flush_val2", 64'(bus.send_val), 64'd0);
    check("t4_empty_flush_fill", 64'(bus.fill_level), 64'd0);

    // Asynchronous reset mid-frame, between clock edges.
    send_sample(8'h77);
    send_sample(8'h88);
    send_sample(8'h99);
    check("t5_fill_pre", 64'(bus.fill_level), 64'd3);
    #2 RESET = 1;
    #1;
    check("t5_rst_recv_rdy", 64'(bus.recv_rdy), 64'd1);
    check("t5_rst_send_val", 64'(bus.send_val), 64'd0);
    check("t5_rst_fill", 64'(bus.fill_level), 64'd0);
    #2 RESET = 0;
    @(posedge CLK); #1;
    bus.send_rdy = 1;
    push_frame(32'hC4C3C2C1, 3'd4);
    send_sample(8'hC1);
    send_sample(8'hC2);
    send_sample(8'hC3);
    send_sample(8'hC4);
    idle(2);
    check("t5_sb_drained", 64'(sb.size()), 64'd0);

    // Random gaps on the input and a toggling consumer over 50 frames.
    fork
      begin
        while (!stall_done) begin
          @(posedge CLK); #1;
          bus.send_rdy = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int f = 0; f < 50; f++) begin
          exp_msg = '0;
          for (int k = 0; k < NS; k++) begin
            d = 8'($urandom);
            exp_msg[k*BW +: BW] = d;
            if (k == NS - 1) push_frame(exp_msg, 3'd4);
            idle($urandom_range(0, 2));
            send_sample(d);
          end
        end
        for (int i = 0; i < 200 && sb.size() != 0; i++) idle(1);
        stall_done = 1;
      end
    join
    bus.send_rdy = 1;
    idle(3);
    check("t6_sb_drained", 64'(sb.size()), 64'd0);
    check("t6_idle_send_val", 64'(bus.send_val), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
